nn_batch_ctrl: RTL

Batch sequencer between the image memory and the network core. It streams NUM_IMAGES images of IMG_PIXELS beats each from memory into the net, one image at a time. After each image it waits for the classification, compares it against a supplied label, and accumulates a correct-prediction count. It replaces free-running read-enable generation with a start/busy/done controlled, timeout-protected, per-image scored flow.

---
 rtl/nn_batch_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/nn_batch_ctrl.sv
// rtl/nn_batch_ctrl.sv - per-image batch sequencer: streams images to the net, scores results, guards waits with a timeout.
// Optional NN_BATCH_LATENCY_EN builds the worst-case classification latency tracker on max_latency.
module nn_batch_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IMG_PIXELS  = 784,
    parameter int NUM_IMAGES  = 16,
    parameter int TIMEOUT     = 4096,
    localparam int CLS_W = $clog2(NUM_CLASSES),
    localparam int PIX_W = $clog2(IMG_PIXELS + 1),
    localparam int IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
    localparam int CNT_W = $clog2(NUM_IMAGES + 1),
    localparam int TMO_W = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_ren,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_last,
    output logic                  net_valid,
    output logic [DATA_WIDTH-1:0] net_data,
    input  logic                  net_out_valid,
    input  logic [CLS_W-1:0]      net_out_data,
    input  logic [CLS_W-1:0]      label_data,
    output logic [IDX_W-1:0]      img_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  result_valid,
    output logic [CLS_W-1:0]      result_digit,
    output logic                  result_match,
    output logic [CNT_W-1:0]      correct_cnt,
    output logic                  len_err,
    output logic                  timeout_err,
    output logic [TMO_W-1:0]      max_latency
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_WAIT   = 3'd2,
        S_RECORD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_mem_ren;
    logic                  r_net_valid;
    logic [DATA_WIDTH-1:0] r_net_data;
    logic [IDX_W-1:0]      r_img_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_res_valid;
    logic [CLS_W-1:0]      r_res_digit;
    logic                  r_res_match;
    logic [CNT_W-1:0]      r_correct;
    logic                  r_len_err;
    logic                  r_tmo_err;
    logic [PIX_W-1:0]      r_pix_cnt;
    logic                  r_pix_ovf;
    logic [TMO_W-1:0]      r_timer;

    logic w_last_img;
    logic w_len_ok;
    logic w_match;
    logic w_tmo_hit;

    assign w_last_img = (r_img_idx == IDX_W'(NUM_IMAGES - 1));
    // r_pix_cnt has not yet counted the mem_last beat itself
    assign w_len_ok   = !r_pix_ovf && (r_pix_cnt == PIX_W'(IMG_PIXELS - 1));
    assign w_match    = (net_out_data == label_data);
    assign w_tmo_hit  = (r_timer == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_ren   <= 1'b0;
            r_net_valid <= 1'b0;
            r_net_data  <= '0;
            r_img_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_digit <= '0;
            r_res_match <= 1'b0;
            r_correct   <= '0;
            r_len_err   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_pix_cnt   <= '0;
            r_pix_ovf   <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_net_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_STREAM;
                        r_busy    <= 1'b1;
                        r_mem_ren <= 1'b1;
                        r_img_idx <= '0;
                        r_correct <= '0;
                        r_pix_cnt <= '0;
                        r_pix_ovf <= 1'b0;
                        r_timer   <= '0;
                        r_len_err <= 1'b0;
                        r_tmo_err <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (mem_valid) begin
                        r_net_valid <= 1'b1;
                        r_net_data  <= mem_data;
                        if (r_pix_cnt == PIX_W'(IMG_PIXELS))
                            r_pix_ovf <= 1'b1;
                        else
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        if (mem_last) begin
                            r_state   <= S_WAIT;
                            r_mem_ren <= 1'b0;
                            r_timer   <= '0;
                            if (!w_len_ok)
                                r_len_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // a result arriving on the last allowed cycle beats the timeout
                    if (net_out_valid) begin
                        r_state     <= S_RECORD;
                        r_res_valid <= 1'b1;
                        r_res_digit <= net_out_data;
                        r_res_match <= w_match;
                        if (w_match && (r_correct != CNT_W'(NUM_IMAGES)))
                            r_correct <= r_correct + 1'b1;
                    end else if (w_tmo_hit) begin
                        r_state   <= S_DONE;
                        r_tmo_err <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RECORD: begin
                    if (w_last_img) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= S_STREAM;
                        r_img_idx <= r_img_idx + 1'b1;
                        r_pix_cnt <= '0;
                        r_pix_ovf <= 1'b0;
                        r_timer   <= '0;
                        r_mem_ren <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef NN_BATCH_LATENCY_EN
    logic [TMO_W-1:0] r_max_lat;
    logic [TMO_W-1:0] w_lat;

    // WAIT duration counts the cycle in which the result is sampled
    assign w_lat = r_timer + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_lat <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_max_lat <= '0;
        end else if ((r_state == S_WAIT) && net_out_valid && (w_lat > r_max_lat)) begin
            r_max_lat <= w_lat;
        end
    end

    assign max_latency = r_max_lat;
`else
    assign max_latency = '0;
`endif

    assign mem_ren      = r_mem_ren;
    assign net_valid    = r_net_valid;
    assign net_data     = r_net_data;
    assign img_idx      = r_img_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_res_valid;
    assign result_digit = r_res_digit;
    assign result_match = r_res_match;
    assign correct_cnt  = r_correct;
    assign len_err      = r_len_err;
    assign timeout_err  = r_tmo_err;

endmodule
